// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch front end.
//   fetchState_e  - bus transaction state of the fetch unit
//   RESET_PC_DEF  - default boot PC
//   NOP_WORD      - instruction word presented for a faulting PC
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,  // request not yet accepted
    WAIT   = 2'd1,  // accepted, awaiting data
    HOLD   = 2'd2,  // data buffered while the pipeline is stalled
    CANCEL = 2'd3   // outstanding response will be discarded
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation and instruction fetch over an SRAM-like bus
// with at most one outstanding request.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   stallF                   - fetch output not accepted this cycle
//   redirect_exc/_exc_pc     - exception/eret redirect (highest priority)
//   redirect_br/_br_pc       - branch/jump redirect
//   inst_req, inst_addr      - bus request and address (address = PC)
//   inst_addr_ok             - address accepted
//   inst_data_ok, inst_rdata - read data valid / data
//   validF, instrF, pcF      - deliverable instruction, its word and PC
//   pc_errorF                - delivered PC is misaligned (instrF is a nop)
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              redirect_exc,
  input  logic [ADDR_W-1:0] redirect_exc_pc,
  input  logic              redirect_br,
  input  logic [ADDR_W-1:0] redirect_br_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              validF,
  output logic [31:0]       instrF,
  output logic [ADDR_W-1:0] pcF,
  output logic              pc_errorF
);

  fetchState_e       state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext, pcInc, redirTgt;
  logic [31:0]       instBuf;
  logic              bufLoad, misaligned, redir, reqAccepted;
  logic              validRaw, errRaw;
  logic [31:0]       instrRaw;

  assign misaligned  = pc[1:0] != 2'b00;
  assign redir       = redirect_exc | redirect_br;
  assign redirTgt    = redirect_exc ? redirect_exc_pc : redirect_br_pc;
  assign pcInc       = pc + ADDR_W'(4);

  // Request depends only on state/pc, never on read data.
  assign inst_req    = (state == REQ) & ~rst & ~misaligned;
  assign inst_addr   = pc;
  assign reqAccepted = inst_req & inst_addr_ok;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    bufLoad   = 1'b0;
    validRaw  = 1'b0;
    errRaw    = 1'b0;
    instrRaw  = NOP_WORD;
    case (state)
      REQ: begin
        if (misaligned) begin
          // Faulting PC: no bus access, deliver a nop tagged with the error.
          validRaw = 1'b1;
          errRaw   = 1'b1;
          if (redir)        pcNext = redirTgt;
          else if (!stallF) pcNext = pcInc;
        end else if (reqAccepted) begin
          stateNext = redir ? CANCEL : WAIT;
          if (redir) pcNext = redirTgt;
        end else if (redir) begin
          pcNext = redirTgt;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          validRaw = 1'b1;
          instrRaw = inst_rdata;
          if (redir) begin
            pcNext    = redirTgt;
            stateNext = REQ;
          end else if (!stallF) begin
            pcNext    = pcInc;
            stateNext = REQ;
          end else begin
            bufLoad   = 1'b1;
            stateNext = HOLD;
          end
        end else if (redir) begin
          pcNext    = redirTgt;
          stateNext = CANCEL;
        end
      end
      HOLD: begin
        validRaw = 1'b1;
        instrRaw = instBuf;
        if (redir) begin
          pcNext    = redirTgt;
          stateNext = REQ;
        end else if (!stallF) begin
          pcNext    = pcInc;
          stateNext = REQ;
        end
      end
      CANCEL: begin
        if (redir)        pcNext    = redirTgt;
        if (inst_data_ok) stateNext = REQ;
      end
      default: stateNext = REQ;
    endcase
  end

  // A redirect (or reset) kills whatever is being delivered this cycle.
  assign validF    = validRaw & ~redir & ~rst;
  assign pc_errorF = errRaw & validF;
  assign instrF    = validF ? instrRaw : NOP_WORD;
  assign pcF       = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      // Remember a transaction still in flight so its late response is
      // swallowed. A response arriving in the reset cycle itself closes it;
      // a CANCEL still waiting keeps waiting across a multi-cycle reset.
      if ((state == WAIT   && !inst_data_ok) ||
          (state == REQ    && inst_addr_ok && !misaligned) ||
          (state == CANCEL && !inst_data_ok))
        state <= CANCEL;
      else
        state <= REQ;
    end else begin
      pc    <= pcNext;
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          instBuf <= NOP_WORD;
    else if (bufLoad) instBuf <= inst_rdata;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirect_exc, redirect_br;
  logic [31:0] redirect_exc_pc, redirect_br_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        validF;
  logic [31:0] instrF, pcF;
  logic        pc_errorF;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .stallF(stallF),
    .redirect_exc(redirect_exc), .redirect_exc_pc(redirect_exc_pc),
    .redirect_br(redirect_br), .redirect_br_pc(redirect_br_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .validF(validF), .instrF(instrF), .pcF(pcF), .pc_errorF(pc_errorF)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    stallF       = 1'b0;
    redirect_exc = 1'b0;
    redirect_br  = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  // One clean two-cycle fetch from an aligned PC.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    inst_addr_ok = 1'b1; settle();
    chk({tag, ".req"},  32'(inst_req), 32'd1);
    chk({tag, ".addr"}, inst_addr, addr);
    chk({tag, ".v0"},   32'(validF), 32'd0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = word; settle();
    chk({tag, ".noreq"}, 32'(inst_req), 32'd0);
    chk({tag, ".v1"},    32'(validF), 32'd1);
    chk({tag, ".instr"}, instrF, word);
    chk({tag, ".pcF"},   pcF, addr);
    tick();
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; redirect_exc = 1'b0; redirect_br = 1'b0;
    redirect_exc_pc = 32'h0; redirect_br_pc = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

    // Reset
    tick(); rst = 1'b1; settle();
    chk("rst.req", 32'(inst_req), 32'd0);
    chk("rst.valid", 32'(validF), 32'd0);
    tick(); rst = 1'b0; settle();
    chk("post.valid", 32'(validF), 32'd0);
    chk("post.instr", instrF, 32'h0);
    chk("post.err", 32'(pc_errorF), 32'd0);
    chk("post.pcF", pcF, 32'hBFC0_0000);
    chk("post.req", 32'(inst_req), 32'd1);

    // Back-to-back fetches, one instruction every two cycles
    fetch("f0", 32'hBFC0_0000, 32'h1111_1111);
    fetch("f1", 32'hBFC0_0004, 32'h2222_2222);

    // Stall: data arrives with stallF high for three cycles
    inst_addr_ok = 1'b1; settle();
    chk("st.addr", inst_addr, 32'hBFC0_0008);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h2402_0001; stallF = 1'b1; settle();
    chk("st.v0", 32'(validF), 32'd1);
    chk("st.i0", instrF, 32'h2402_0001);
    for (int i = 1; i < 3; i++) begin
      tick(); stallF = 1'b1; settle();
      chk($sformatf("st.v%0d", i), 32'(validF), 32'd1);
      chk($sformatf("st.i%0d", i), instrF, 32'h2402_0001);
      chk($sformatf("st.req%0d", i), 32'(inst_req), 32'd0);
    end
    tick(); settle();
    chk("st.v3", 32'(validF), 32'd1);
    chk("st.i3", instrF, 32'h2402_0001);
    chk("st.pc3", pcF, 32'hBFC0_0008);
    chk("st.req3", 32'(inst_req), 32'd0);
    tick(); settle();
    chk("st.next", 32'(inst_req), 32'd1);
    chk("st.naddr", inst_addr, 32'hBFC0_000C);

    // Branch redirect while waiting for data
    inst_addr_ok = 1'b1; settle();
    tick();
    redirect_br = 1'b1; redirect_br_pc = 32'hBFC0_0100; settle();
    chk("rw.v", 32'(validF), 32'd0);
    tick(); settle();
    chk("rw.req0", 32'(inst_req), 32'd0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h3333_3333; settle();
    chk("rw.drop", 32'(validF), 32'd0);
    chk("rw.req1", 32'(inst_req), 32'd0);
    tick();
    fetch("rw.f", 32'hBFC0_0100, 32'h3434_3434);

    // Exception beats branch in the same cycle
    redirect_exc = 1'b1; redirect_exc_pc = 32'hBFC0_0380;
    redirect_br  = 1'b1; redirect_br_pc  = 32'hBFC0_0200; settle();
    chk("pri.v", 32'(validF), 32'd0);
    tick();
    fetch("pri.f", 32'hBFC0_0380, 32'h4444_4444);

    // Redirect to a misaligned PC
    redirect_br = 1'b1; redirect_br_pc = 32'hBFC0_0102; settle();
    tick(); settle();
    chk("mis.req", 32'(inst_req), 32'd0);
    chk("mis.v", 32'(validF), 32'd1);
    chk("mis.err", 32'(pc_errorF), 32'd1);
    chk("mis.instr", instrF, 32'h0);
    chk("mis.pcF", pcF, 32'hBFC0_0102);
    tick(); stallF = 1'b1; settle();
    chk("mis2.pcF", pcF, 32'hBFC0_0106);
    chk("mis2.err", 32'(pc_errorF), 32'd1);
    chk("mis2.req", 32'(inst_req), 32'd0);
    tick(); stallF = 1'b1; settle();
    chk("mis3.hold", pcF, 32'hBFC0_0106);
    redirect_br = 1'b1; redirect_br_pc = 32'hBFC0_0200; settle();
    chk("mis3.kill", 32'(validF), 32'd0);
    chk("mis3.kerr", 32'(pc_errorF), 32'd0);
    tick();
    fetch("mis.f", 32'hBFC0_0200, 32'h5151_5151);

    // Redirect while holding stalled data drops the buffer
    inst_addr_ok = 1'b1; settle();
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h5252_5252; stallF = 1'b1; settle();
    tick();
    stallF = 1'b1; redirect_br = 1'b1; redirect_br_pc = 32'hBFC0_0300; settle();
    chk("hold.kill", 32'(validF), 32'd0);
    tick();
    fetch("hold.f", 32'hBFC0_0300, 32'h5353_5353);

    // Reset with a request outstanding; stray response must be dropped
    inst_addr_ok = 1'b1; settle();
    tick();
    rst = 1'b1; settle();
    chk("rw.rst.req", 32'(inst_req), 32'd0);
    tick(); rst = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555; settle();
    chk("stray.v", 32'(validF), 32'd0);
    chk("stray.req", 32'(inst_req), 32'd0);
    tick();
    fetch("boot", 32'hBFC0_0000, 32'h6666_6666);

    // PC wraps modulo 2^32
    redirect_br = 1'b1; redirect_br_pc = 32'hFFFF_FFFC; settle();
    tick();
    fetch("wrap.f", 32'hFFFF_FFFC, 32'h7777_7777);
    settle();
    chk("wrap.addr", inst_addr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
